// File: rtl/dot25_mac_unit_pkg.sv
// Shared definitions for the dot25 MAC responder and the layer controllers
// that talk to it.
//   - Default word format (Q7.8) and vector length.
//   - CALC_LATENCY: edges from an accepted bundle to its out_valid_o pulse.
//   - Bundle field offsets and the rounding and saturation constants.
package dot25_mac_unit_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int FRAC_DEF     = 8;
    localparam int N_DEF        = 25;
    localparam int CALC_LATENCY = 7;
    // Guard bits on the accumulator. 25 products need ceil(log2(25)) = 5
    // bits. The sixth bit leaves headroom.
    localparam int ACC_GUARD    = 6;

    // MSB of VecA word idx inside the packed bundle.
    function automatic int vec_a_msb(input int idx, input int width, input int n);
        return width * (2 * n + 1) - 1 - width * idx;
    endfunction

    // MSB of VecB word idx inside the packed bundle.
    function automatic int vec_b_msb(input int idx, input int width, input int n);
        return width * (n + 1) - 1 - width * idx;
    endfunction

    // Half an output LSB, added before the arithmetic shift so that
    // ties round toward +inf.
    function automatic longint round_half(input int frac);
        return longint'(1) <<< (frac - 1);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/dot25_mac_unit_add_tree_stage.sv
// One registered level of the pairwise adder tree.
// Ports:
//   clk     rising-edge clock
//   i_en    capture enable, driven by the valid bit of the upstream stage
//   i_data  M packed words of W bits. Word j is at [j*W +: W].
//   o_data  ceil(M/2) packed words. Word j is in[2j] + in[2j+1].
//           When M is odd, the last input word passes through unchanged.
// The words are two's complement. W is wide enough that no sum overflows,
// so plain modular addition is exact.
module add_tree_stage #(
    parameter int M = 25,
    parameter int W = 38
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [M*W-1:0]           i_data,
    output logic [((M+1)/2)*W-1:0]   o_data
);
    localparam int MO = (M + 1) / 2;

    logic [MO*W-1:0] w_sum;
    logic [MO*W-1:0] r_sum;

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < M / 2; j++) begin
            w_sum[j*W +: W] = i_data[2*j*W +: W] + i_data[(2*j+1)*W +: W];
        end
        if (M % 2 == 1) begin
            w_sum[(MO-1)*W +: W] = i_data[(M-1)*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_sum <= w_sum;
        end
    end

    assign o_data = r_sum;

endmodule

// File: rtl/dot25_mac_unit.sv
// Pipelined fixed-point dot product responder: sum(VecA[i]*VecB[i]) + Bias.
// The result is rounded, saturated and optionally passed through ReLU.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   in_valid_i   data_i holds a bundle this cycle
//   data_i       packed {VecA[0..N-1], VecB[0..N-1], Bias}
//   clear_sat_i  clears sat_o; a new saturation on the same cycle wins
//   out_valid_o  one-cycle pulse per bundle, CALC_LATENCY edges after acceptance
//   data_o       result; holds its value between pulses
//   busy_o       a bundle is somewhere in stages 1-7
//   sat_o        sticky: some result was clamped since reset or clear
// Pipeline:
//   Stage 1 holds the products. Stages 2-6 are the adder tree
//   (25 -> 13 -> 7 -> 4 -> 2 -> 1). Stage 7 adds the bias. The output
//   register rounds, saturates and applies ReLU. With N = 25 the five tree
//   levels reduce to exactly one word.
module dot25_mac_unit
    import dot25_mac_unit_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int N       = N_DEF,
    parameter bit RELU_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    input  logic [WIDTH*(2*N+1)-1:0] data_i,
    input  logic                     clear_sat_i,
    output logic                     out_valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     busy_o,
    output logic                     sat_o
);
    localparam int ACC_W = 2 * WIDTH + ACC_GUARD;
    // One extra bit so that the bias add cannot wrap.
    localparam int S_W   = ACC_W + 1;

    localparam int M1 = N;
    localparam int M2 = (M1 + 1) / 2;
    localparam int M3 = (M2 + 1) / 2;
    localparam int M4 = (M3 + 1) / 2;
    localparam int M5 = (M4 + 1) / 2;
    localparam int M6 = (M5 + 1) / 2;

    localparam logic signed [S_W-1:0] C_ROUND = S_W'(round_half(FRAC));
    localparam logic signed [S_W-1:0] C_MAX   = S_W'(sat_max(WIDTH));
    localparam logic signed [S_W-1:0] C_MIN   = S_W'(sat_min(WIDTH));

    // r_vld[s-1] is the valid bit of stage s.
    logic [CALC_LATENCY-1:0] r_vld;

    logic [N*ACC_W-1:0]      w_prod;
    logic [N*ACC_W-1:0]      r_prod;
    logic [M2*ACC_W-1:0]     w_t2;
    logic [M3*ACC_W-1:0]     w_t3;
    logic [M4*ACC_W-1:0]     w_t4;
    logic [M5*ACC_W-1:0]     w_t5;
    logic [M6*ACC_W-1:0]     w_t6;
    // Bias rides alongside the tree through stages 1-6.
    logic [WIDTH-1:0]        r_bias [CALC_LATENCY-1];
    logic signed [S_W-1:0]   w_bias_ext;
    logic signed [S_W-1:0]   w_acc_next;
    logic signed [S_W-1:0]   r_acc;
    logic signed [S_W-1:0]   w_rnd;
    logic                    w_clamp_hi;
    logic                    w_clamp_lo;
    logic [WIDTH-1:0]        w_sat_val;
    logic [WIDTH-1:0]        w_out;

    // Stage 1: signed products, sign-extended to the accumulator width.
    always_comb begin
        logic signed [WIDTH-1:0]   a_w;
        logic signed [WIDTH-1:0]   b_w;
        logic signed [2*WIDTH-1:0] p_w;
        w_prod = '0;
        a_w    = '0;
        b_w    = '0;
        p_w    = '0;
        for (int i = 0; i < N; i++) begin
            a_w = data_i[vec_a_msb(i, WIDTH, N) -: WIDTH];
            b_w = data_i[vec_b_msb(i, WIDTH, N) -: WIDTH];
            p_w = a_w * b_w;
            w_prod[i*ACC_W +: ACC_W] = {{ACC_GUARD{p_w[2*WIDTH-1]}}, p_w};
        end
    end

    // Stages 2-6: adder tree. Each level is enabled by the valid bit of the
    // level feeding it.
    add_tree_stage #(.M(M1), .W(ACC_W)) u_tree_s2 (
        .clk    (clk),
        .i_en   (r_vld[0]),
        .i_data (r_prod),
        .o_data (w_t2)
    );

    add_tree_stage #(.M(M2), .W(ACC_W)) u_tree_s3 (
        .clk    (clk),
        .i_en   (r_vld[1]),
        .i_data (w_t2),
        .o_data (w_t3)
    );

    add_tree_stage #(.M(M3), .W(ACC_W)) u_tree_s4 (
        .clk    (clk),
        .i_en   (r_vld[2]),
        .i_data (w_t3),
        .o_data (w_t4)
    );

    add_tree_stage #(.M(M4), .W(ACC_W)) u_tree_s5 (
        .clk    (clk),
        .i_en   (r_vld[3]),
        .i_data (w_t4),
        .o_data (w_t5)
    );

    add_tree_stage #(.M(M5), .W(ACC_W)) u_tree_s6 (
        .clk    (clk),
        .i_en   (r_vld[4]),
        .i_data (w_t5),
        .o_data (w_t6)
    );

    // Stage 7: align the Q7.8 bias to the Q15.16 sum, then add.
    always_comb begin
        w_bias_ext = S_W'(signed'(r_bias[CALC_LATENCY-2]));
        w_bias_ext = w_bias_ext <<< FRAC;
        w_acc_next = S_W'(signed'(w_t6[ACC_W-1:0])) + w_bias_ext;
    end

    // Output: round half toward +inf, saturate, then ReLU. Saturation is
    // detected before ReLU so that a large negative result still sets sat_o.
    always_comb begin
        w_rnd      = (r_acc + C_ROUND) >>> FRAC;
        w_clamp_hi = (w_rnd > C_MAX);
        w_clamp_lo = (w_rnd < C_MIN);
        if (w_clamp_hi) begin
            w_sat_val = C_MAX[WIDTH-1:0];
        end else if (w_clamp_lo) begin
            w_sat_val = C_MIN[WIDTH-1:0];
        end else begin
            w_sat_val = w_rnd[WIDTH-1:0];
        end
        w_out = w_sat_val;
        if (RELU_EN && w_sat_val[WIDTH-1]) begin
            w_out = '0;
        end
    end

    // Control path. The valid bits advance every cycle whether or not a
    // bundle arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            out_valid_o <= 1'b0;
            data_o      <= '0;
            busy_o      <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            r_vld       <= {r_vld[CALC_LATENCY-2:0], in_valid_i};
            out_valid_o <= r_vld[CALC_LATENCY-1];
            busy_o      <= |r_vld;
            if (r_vld[CALC_LATENCY-1]) begin
                data_o <= w_out;
            end
            if (r_vld[CALC_LATENCY-1] && (w_clamp_hi || w_clamp_lo)) begin
                sat_o <= 1'b1;
            end else if (clear_sat_i) begin
                sat_o <= 1'b0;
            end
        end
    end

    // Data path. It has no reset; a data register is meaningful only while
    // its stage valid bit is set.
    always_ff @(posedge clk) begin
        if (in_valid_i) begin
            r_prod    <= w_prod;
            r_bias[0] <= data_i[WIDTH-1:0];
        end
        for (int s = 1; s < CALC_LATENCY - 1; s++) begin
            if (r_vld[s-1]) begin
                r_bias[s] <= r_bias[s-1];
            end
        end
        if (r_vld[CALC_LATENCY-2]) begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: doc/dot25_mac_unit.md
Name: dot25_mac_unit

Overview:
- Calculation responder on the far end of the convolution/dense layer "data_to_calc / data_from_calc" interface.
- Accepts one packed {VecA, VecB, Bias} bundle per cycle. Computes the signed fixed-point dot product of two 25-word vectors plus bias, with optional ReLU.
- Returns one 16-bit result a fixed 7 cycles later.
- Fully pipelined, no backpressure; layer controllers track results with a 7-cycle valid delay.

Parameters:
- WIDTH, 16, word width (signed fixed point).
- FRAC, 8, fractional bits (Q7.8 in, Q7.8 out).
- N, 25, vector length; the packed bundle is (2*N+1)*WIDTH bits.
- RELU_EN, 1, 1 = clamp negative results to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid_i  in  1  data_i holds a bundle this cycle.
- data_i  in  WIDTH*(2*N+1)  packed bundle:
  - VecA word i at [WIDTH*(2N+1)-1-WIDTH*i -: WIDTH].
  - VecB word i at [WIDTH*(N+1)-1-WIDTH*i -: WIDTH].
  - Bias at [WIDTH-1:0].
- out_valid_o  out  1  data_o valid, single-cycle pulse per accepted bundle.
- data_o  out  WIDTH  result.
- busy_o  out  1  any valid bundle in flight (stages 1-7).
- sat_o  out  1  sticky flag: some result saturated since reset/clear.
- clear_sat_i  in  1  clears sat_o next cycle; set has priority on the same cycle.

Behaviour:
- Reset values: out_valid_o=0, data_o=0, busy_o=0, sat_o=0. All stage valid bits are 0; data registers don't care.
- Latency is exactly 7 cycles: in_valid_i sampled at edge k gives out_valid_o high after edge k+7. Throughput is 1 bundle per cycle.
- Stage 1: register 25 signed products VecA[i]*VecB[i], each 2*WIDTH bits (Q15.16).
- Stages 2-6: pipelined adder tree 25→13→7→4→2→1.
  - Odd element passes through registered.
  - Accumulator width is 2*WIDTH+6 = 38 bits, sign-extended; the tree never overflows.
- Stage 7:
  - sum + (sign-extended Bias <<< FRAC).
  - Add 1<<(FRAC-1), then arithmetic shift right by FRAC (round half toward +inf).
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If RELU_EN and result < 0, output 0.
  - Register into data_o.
- sat_o sets on any stage-7 valid cycle where clamping occurred, checked before ReLU.
- Valid bits form a 7-bit shift register that advances every cycle regardless of in_valid_i; data is captured only when the stage valid is 1.
- data_o holds its last value while out_valid_o=0.
- No backpressure, no stall: consumers must sample on out_valid_o.
- rst mid-operation clears all valid bits; in-flight bundles are discarded and produce no out_valid_o afterwards. in_valid_i during rst is ignored.
- busy_o = OR of the stage 1-7 valid bits, registered consistently with the pipeline.

Decomposition:
- Shared package holds: WIDTH/FRAC defaults, CALC_LATENCY=7 (layer controllers use it for their valid delay), bundle field offset functions, and the saturate/round constants.
- One natural sub-module: add_tree_stage, a parameterized registered pairwise adder for M inputs producing ceil(M/2) outputs. Instantiate it 5 times.

Test Plan:
- All VecA=0x0100, VecB=0x0100, Bias=0 → data_o=0x1900 exactly 7 cycles later, out_valid_o one pulse, sat_o=0.
- VecA=VecB=0x7FFF all words, Bias=0x7FFF → data_o=0x7FFF, sat_o=1 and stays 1 until clear_sat_i pulse, then 0.
- Rounding with RELU_EN=0:
  - VecA[0]=0x0001, VecB[0]=0x0080, rest 0, Bias 0 → 0x0001.
  - VecA[0]=0xFFFF, VecB[0]=0x0080 → 0x0000.
  - Bias=0xFF00 only → 0xFF00.
- ReLU with RELU_EN=1: Bias=0xFF00, vectors 0 → data_o=0x0000 with out_valid_o=1.
- Back-to-back: 3 bundles on consecutive cycles (expected 0x0100, 0x0200, 0x0300 via Bias) → 3 consecutive out_valid_o pulses in order; busy_o high 9 cycles total.
- Feed 4 bundles, assert rst for 1 cycle after the 4th → no out_valid_o for the following 10 cycles; busy_o=0 after rst.
